// File: rtl/imem_responder_if.sv
// Fetch-side and SRAM-side signals of the instruction-fetch responder.
interface imem_responder_if #(
    parameter int unsigned SRAM_AW = 20
);
    logic               ice;
    logic [31:0]        iaddr;
    logic               inv;
    logic [31:0]        inst;
    logic               stallreq_if;
    logic               adel_if;
    logic [SRAM_AW-1:0] sram_addr;
    logic               sram_ce_n;
    logic               sram_oe_n;
    logic [31:0]        sram_data_i;

    modport slave (
        input  ice, iaddr, inv, sram_data_i,
        output inst, stallreq_if, adel_if, sram_addr, sram_ce_n, sram_oe_n
    );

    modport master (
        output ice, iaddr, inv, sram_data_i,
        input  inst, stallreq_if, adel_if, sram_addr, sram_ce_n, sram_oe_n
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction-fetch responder: single-entry fetch buffer in front of an
// asynchronous SRAM with a fixed number of read wait states.
module imem_responder #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned SRAM_AW     = 20
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst,
    imem_responder_if.slave   bus
);
    typedef enum logic {IDLE, ACCESS} state_t;

    state_t             state;
    logic               buf_valid;
    logic [29:0]        buf_tag;
    logic [31:0]        buf_data;
    logic [29:0]        lat_tag;
    logic [SRAM_AW-1:0] lat_addr;
    logic [3:0]         wcnt;
    logic               ce_n;
    logic               oe_n;

    logic misaligned;
    logic hit;
    logic miss;

    always_comb begin
        misaligned = bus.iaddr[1:0] != 2'b00;
        hit        = buf_valid && (buf_tag == bus.iaddr[31:2]);
        miss       = (state == IDLE) && bus.ice && !misaligned && !hit;
    end

    always_comb begin
        bus.inst        = '0;
        bus.adel_if     = 1'b0;
        bus.stallreq_if = (state == ACCESS) || miss;
        if (state == IDLE && bus.ice) begin
            bus.adel_if = misaligned;
            if (!misaligned && hit)
                bus.inst = buf_data;
        end
        bus.sram_addr = lat_addr;
        bus.sram_ce_n = ce_n;
        bus.sram_oe_n = oe_n;
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            state     <= IDLE;
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
            lat_tag   <= '0;
            lat_addr  <= '0;
            wcnt      <= '0;
            ce_n      <= 1'b1;
            oe_n      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        lat_addr <= bus.iaddr[SRAM_AW+1:2];
                        lat_tag  <= bus.iaddr[31:2];
                        wcnt     <= 4'(WAIT_CYCLES);
                        ce_n     <= 1'b0;
                        oe_n     <= 1'b0;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Runs to completion on the latched address whatever the fetch stage does.
                    if (wcnt != 4'd0) begin
                        wcnt <= wcnt - 4'd1;
                    end else begin
                        buf_data  <= bus.sram_data_i;
                        buf_tag   <= lat_tag;
                        buf_valid <= 1'b1;
                        ce_n      <= 1'b1;
                        oe_n      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (bus.inv)
                buf_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: per-cycle vector table through a
// scoreboard queue, plus a hand sequence on a zero-wait-state instance.
module tb_imem_responder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_responder_if #(.SRAM_AW(20)) bus  ();
    imem_responder_if #(.SRAM_AW(20)) bus0 ();

    imem_responder #(.WAIT_CYCLES(2), .SRAM_AW(20)) u_dut (
        .cpu_clk_50M(clk), .cpu_rst(rst), .bus(bus.slave));
    imem_responder #(.WAIT_CYCLES(0), .SRAM_AW(20)) u_dut0 (
        .cpu_clk_50M(clk), .cpu_rst(rst), .bus(bus0.slave));

    function automatic logic [31:0] mem(input logic [19:0] a);
        return (a == 20'd0) ? 32'h3C010001 : {12'hC0D, a};
    endfunction

    assign bus.sram_data_i  = (!bus.sram_ce_n && !bus.sram_oe_n) ? mem(bus.sram_addr) : 32'hDEADBEEF;
    assign bus0.sram_data_i = (!bus0.sram_ce_n && !bus0.sram_oe_n) ? mem(bus0.sram_addr) : 32'hDEADBEEF;

    typedef struct {
        bit          rst;
        bit          ice;
        logic [31:0] iaddr;
        bit          inv;
        logic [31:0] e_inst;
        bit          e_stall;
        bit          e_adel;
        bit          e_ce_n;
        bit          chk_addr;
        logic [19:0] e_addr;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int tests = 0;
    int fails = 0;

    task automatic v(input bit r, input bit ice, input logic [31:0] a, input bit inv,
                     input logic [31:0] ei, input bit es, input bit ea, input bit ec,
                     input bit ck, input logic [19:0] eaddr);
        vec_t t;
        t.rst = r; t.ice = ice; t.iaddr = a; t.inv = inv;
        t.e_inst = ei; t.e_stall = es; t.e_adel = ea; t.e_ce_n = ec;
        t.chk_addr = ck; t.e_addr = eaddr;
        vecs.push_back(t);
    endtask

    // Full miss with WAIT_CYCLES=2: decision cycle, three ACCESS cycles, then the hit.
    task automatic miss_seq(input logic [31:0] a, input logic [19:0] wa, input logic [31:0] d);
        v(0, 1, a, 0, 32'h0, 1, 0, 1, 0, 20'h0);
        for (int i = 0; i < 3; i++) v(0, 1, a, 0, 32'h0, 1, 0, 0, 1, wa);
        v(0, 1, a, 0, d, 0, 0, 1, 0, 20'h0);
    endtask

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    initial begin
        vec_t e;
        rst = 1'b1;
        bus.ice = 1'b0;  bus.iaddr = '0;  bus.inv = 1'b0;
        bus0.ice = 1'b0; bus0.iaddr = '0; bus0.inv = 1'b0;
        repeat (2) @(posedge clk);

        v(1, 0, 32'h0, 0, 32'h0, 0, 0, 1, 1, 20'h0);
        miss_seq(32'h0, 20'h0, 32'h3C010001);
        v(0, 1, 32'h0, 0, 32'h3C010001, 0, 0, 1, 0, 20'h0);
        miss_seq(32'h4, 20'h1, 32'hC0D00001);
        v(0, 1, 32'h6, 0, 32'h0, 0, 1, 1, 0, 20'h0);
        // Miss on 0x10, fetch stage redirects to 0x80 mid-access.
        v(0, 1, 32'h10, 0, 32'h0, 1, 0, 1, 0, 20'h0);
        v(0, 1, 32'h10, 0, 32'h0, 1, 0, 0, 1, 20'h4);
        v(0, 0, 32'h80, 0, 32'h0, 1, 0, 0, 1, 20'h4);
        v(0, 1, 32'h80, 0, 32'h0, 1, 0, 0, 1, 20'h4);
        v(0, 1, 32'h80, 0, 32'h0, 1, 0, 1, 0, 20'h0);
        v(0, 1, 32'h80, 0, 32'h0, 1, 0, 0, 1, 20'h20);
        v(0, 1, 32'h80, 0, 32'h0, 1, 0, 0, 1, 20'h20);
        v(0, 1, 32'h80, 1, 32'h0, 1, 0, 0, 1, 20'h20);
        miss_seq(32'h80, 20'h20, 32'hC0D00020);
        // Buffer keeps the latched address even with ice low and iaddr elsewhere.
        v(0, 1, 32'h10, 0, 32'h0, 1, 0, 1, 0, 20'h0);
        for (int i = 0; i < 3; i++) v(0, 0, 32'h80, 0, 32'h0, 1, 0, 0, 1, 20'h4);
        v(0, 1, 32'h10, 0, 32'hC0D00004, 0, 0, 1, 0, 20'h0);
        // inv together with a miss still starts the access.
        v(0, 1, 32'h20, 1, 32'h0, 1, 0, 1, 0, 20'h0);
        for (int i = 0; i < 3; i++) v(0, 1, 32'h20, 0, 32'h0, 1, 0, 0, 1, 20'h8);
        v(0, 1, 32'h20, 0, 32'hC0D00008, 0, 0, 1, 0, 20'h0);
        v(0, 1, 32'h20, 1, 32'hC0D00008, 0, 0, 1, 0, 20'h0);
        miss_seq(32'h20, 20'h8, 32'hC0D00008);
        // Reset in the first wait cycle of an access.
        v(0, 1, 32'h40, 0, 32'h0, 1, 0, 1, 0, 20'h0);
        v(1, 1, 32'h40, 0, 32'h0, 1, 0, 0, 1, 20'h10);
        v(0, 0, 32'h40, 0, 32'h0, 0, 0, 1, 1, 20'h0);
        miss_seq(32'h20, 20'h8, 32'hC0D00008);
        miss_seq(32'h40, 20'h10, 32'hC0D00010);
        // Bits above the SRAM range affect the tag only.
        miss_seq(32'h00400000, 20'h0, 32'h3C010001);
        miss_seq(32'h0, 20'h0, 32'h3C010001);

        foreach (vecs[k]) begin
            @(negedge clk);
            rst = vecs[k].rst; bus.ice = vecs[k].ice; bus.iaddr = vecs[k].iaddr; bus.inv = vecs[k].inv;
            sb.push_back(vecs[k]);
            #3;
            e = sb.pop_front();
            chk("inst", k, bus.inst, e.e_inst);
            chk("stallreq_if", k, 32'(bus.stallreq_if), 32'(e.e_stall));
            chk("adel_if", k, 32'(bus.adel_if), 32'(e.e_adel));
            chk("sram_ce_n", k, 32'(bus.sram_ce_n), 32'(e.e_ce_n));
            chk("sram_oe_n", k, 32'(bus.sram_oe_n), 32'(e.e_ce_n));
            if (e.chk_addr) chk("sram_addr", k, 32'(bus.sram_addr), 32'(e.e_addr));
        end

        // WAIT_CYCLES=0: ACCESS lasts exactly one cycle.
        @(negedge clk); rst = 1'b0; bus.ice = 1'b0; bus0.ice = 1'b1; bus0.iaddr = 32'h8; #3;
        chk("w0_decide_stall", 100, 32'(bus0.stallreq_if), 32'd1);
        chk("w0_decide_ce_n", 100, 32'(bus0.sram_ce_n), 32'd1);
        @(negedge clk); #3;
        chk("w0_access_stall", 101, 32'(bus0.stallreq_if), 32'd1);
        chk("w0_access_ce_n", 101, 32'(bus0.sram_ce_n), 32'd0);
        chk("w0_access_addr", 101, 32'(bus0.sram_addr), 32'h2);
        chk("w0_access_inst", 101, bus0.inst, 32'h0);
        @(negedge clk); #3;
        chk("w0_hit_stall", 102, 32'(bus0.stallreq_if), 32'd0);
        chk("w0_hit_ce_n", 102, 32'(bus0.sram_ce_n), 32'd1);
        chk("w0_hit_inst", 102, bus0.inst, 32'hC0D00002);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
